// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command assembler slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic {
        IDLE,
        COLLECT
    } asm_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling, LSB-first shifter.
// Latency: byte_vld_o / frame_err_o register one clk after the stop-bit mid sample.
// Backpressure: none; byte_vld_o is a one-cycle pulse the consumer must take.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   rx_i           raw serial line (asynchronous, idle high)
//   byte_vld_o     one-cycle pulse, byte_data_o holds the received byte
//   byte_data_o    last received byte
//   frame_err_o    one-cycle pulse when the stop bit is sampled low
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic                 byte_vld_o,
    output logic [DATA_BITS-1:0] byte_data_o,
    output logic                 frame_err_o
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(BAUD_DIV / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_fall;

    // Edge detect on the synchronised line only; rx_prev_q is the third
    // stage so the raw pin never reaches the FSM.
    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= R_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (rx_fall) begin
                    state_d = R_START;
                end
            end
            R_START: begin
                // Half a bit in: a line back high means a glitch, not a start bit.
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    state_d = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            R_DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    data_d = {rx_s2_q, data_q[DATA_BITS-1:1]};
                    bit_d  = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) begin
                        state_d = R_STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            R_STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d  = '0;
                    vld_d   = rx_s2_q;
                    ferr_d  = ~rx_s2_q;
                    state_d = R_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign byte_vld_o  = vld_q;
    assign byte_data_o = data_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_cmd_assembler.sv
// Receives 8N1 bytes and assembles NUM_BYTES of them into a held command word.
// Latency: cmd/cmd_rdy update 2 clk after the final byte's stop-bit mid sample.
// Backpressure: none; cmd is overwritten by the next completion regardless of cmd_rdy.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   RX             raw serial line (asynchronous, idle high)
//   clr_cmd_rdy    consumer acknowledge, clears cmd_rdy
//   cmd_rdy        a full command is held in cmd
//   cmd            last completed command (8*NUM_BYTES bits)
//   frame_err      one-cycle pulse, stop bit sampled low
//   timeout_err    one-cycle pulse, partial command dropped after inter-byte timeout
module uart_cmd_assembler
    import uart_pkg::*;
#(
    parameter int NUM_BYTES      = 2,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int BAUD_DIV       = 2604,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RX,
    input  logic                   clr_cmd_rdy,
    output logic                   cmd_rdy,
    output logic [8*NUM_BYTES-1:0] cmd,
    output logic                   frame_err,
    output logic                   timeout_err
);

    localparam int CMD_W = DATA_BITS * NUM_BYTES;
    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BYTES);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    logic                 byte_vld;
    logic [DATA_BITS-1:0] byte_data;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (RX),
        .byte_vld_o  (byte_vld),
        .byte_data_o (byte_data),
        .frame_err_o (frame_err)
    );

    asm_state_t       state_q, state_d;
    logic [CMD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             tmo_err_q, tmo_err_d;

    logic [CMD_W-1:0] asm_base;
    logic [CMD_W-1:0] asm_word;
    logic [CNT_W-1:0] cnt_inc;
    logic [TMO_W-1:0] tmo_inc;

    // Word after shifting in byte_data. In IDLE the base is zero so the
    // first byte is a load rather than a shift into stale contents.
    always_comb begin
        asm_base = (state_q == IDLE) ? '0 : shreg_q;
        if (MSB_FIRST) begin
            asm_word = (asm_base << DATA_BITS) | CMD_W'(byte_data);
        end else begin
            asm_word = (asm_base >> DATA_BITS) | (CMD_W'(byte_data) << (CMD_W - DATA_BITS));
        end
    end

    assign cnt_inc = byte_cnt_q + CNT_W'(1);
    assign tmo_inc = tmo_cnt_q + TMO_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        tmo_err_d  = 1'b0;

        // Clears are applied first so a completion below overrides them.
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (byte_vld) begin
                    cmd_rdy_d = 1'b0;
                    tmo_cnt_d = '0;
                    if (NUM_BYTES == 1) begin
                        cmd_d      = asm_word;
                        cmd_rdy_d  = 1'b1;
                        byte_cnt_d = '0;
                    end else begin
                        shreg_d    = asm_word;
                        byte_cnt_d = CNT_W'(1);
                        state_d    = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (byte_vld) begin
                    tmo_cnt_d = '0;
                    if (cnt_inc == CNT_FULL) begin
                        cmd_d      = asm_word;
                        cmd_rdy_d  = 1'b1;
                        shreg_d    = '0;
                        byte_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        shreg_d    = asm_word;
                        byte_cnt_d = cnt_inc;
                    end
                end else if (frame_err) begin
                    shreg_d    = '0;
                    byte_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tmo_inc == TMO_MAX) begin
                        tmo_err_d  = 1'b1;
                        shreg_d    = '0;
                        byte_cnt_d = '0;
                        tmo_cnt_d  = '0;
                        state_d    = IDLE;
                    end else begin
                        tmo_cnt_d = tmo_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd         = cmd_q;
    assign cmd_rdy     = cmd_rdy_q;
    assign timeout_err = tmo_err_q;

endmodule
